// File: rtl/multiport_read_cache.sv
// multiport_read_cache
//   Direct-mapped, tagged, read-only word cache shared by PORTS clients in
//   front of a single backing-memory read port. Each line holds one 32-bit
//   word. Hits complete one cycle after the lookup. Misses park the port in
//   WAIT, and a fill FSM fetches one line at a time, choosing among the waiting
//   ports in round-robin order.
//
//   Optional feature: define CACHE_STATS_EN to add the hit_count_o and
//   miss_count_o saturating counters. They count first lookups only.
//
// Ports
//   clock         rising-edge system clock
//   reset_n       asynchronous active-low reset
//   flush_i       invalidate all lines (1-cycle pulse)
//   req_i         per-port read request, held until ack
//   addr_i        per-port byte address, packed PORTS x ADDR_W
//   ack_o         per-port 1-cycle completion pulse
//   rdata_o       per-port read data, packed PORTS x 32, valid with ack
//   mem_req_o     backing-memory read request
//   mem_addr_o    backing-memory word address (low 2 bits zero)
//   mem_valid_i   backing-memory data valid
//   mem_data_i    backing-memory read data
//   hit_count_o   (CACHE_STATS_EN) first-lookup hits
//   miss_count_o  (CACHE_STATS_EN) first-lookup misses
module multiport_read_cache #(
  parameter int INDEX_BITS = 6,
  parameter int PORTS      = 2,
  parameter int ADDR_W     = 32
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    flush_i,
  input  logic [PORTS-1:0]        req_i,
  input  logic [PORTS*ADDR_W-1:0] addr_i,
  output logic [PORTS-1:0]        ack_o,
  output logic [PORTS*32-1:0]     rdata_o,
  output logic                    mem_req_o,
  output logic [ADDR_W-1:0]       mem_addr_o,
  input  logic                    mem_valid_i,
  input  logic [31:0]             mem_data_i
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]             hit_count_o,
  output logic [31:0]             miss_count_o
`endif
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_W - INDEX_BITS - 2;
  localparam int PTR_W = (PORTS > 1) ? $clog2(PORTS) : 1;

  typedef enum logic [1:0] {P_IDLE, P_WAIT, P_DONE} portState_e;
  typedef enum logic       {F_IDLE, F_FETCH}        fillState_e;

  // Line storage
  logic [LINES-1:0] lineValid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  // Per-port address decode and lookup
  logic [ADDR_W-1:0]     portAddr [PORTS];
  logic [INDEX_BITS-1:0] portIdx  [PORTS];
  logic [TAG_W-1:0]      portTag  [PORTS];
  logic [PORTS-1:0]      lookupHit;
  logic [PORTS-1:0]      wantFetch;
  logic                  unusedAddrBits;

  // Per-port FSM
  portState_e        portState_q [PORTS];
  portState_e        portState_d [PORTS];
  logic [PORTS*32-1:0] rdata_q, rdata_d;

  // Fill FSM
  fillState_e        fillState_q, fillState_d;
  logic [PTR_W-1:0]  grant_q, grant_d;
  logic [PTR_W-1:0]  rr_q, rr_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic              grantFound;
  logic [PTR_W-1:0]  grantIdx;
  logic              fetching;
  logic              fillDone;
  logic [INDEX_BITS-1:0] fillIdx;
  logic [TAG_W-1:0]      fillTag;

  assign fetching = (fillState_q == F_FETCH);
  assign fillDone = fetching && mem_valid_i;
  assign fillIdx  = memAddr_q[INDEX_BITS+1:2];
  assign fillTag  = memAddr_q[ADDR_W-1:INDEX_BITS+2];

  // A lookup made while flush is high reports a miss. The line is about to be
  // invalidated, so the flush must not let a stale hit slip through.
  always_comb begin
    lookupHit      = '0;
    wantFetch      = '0;
    unusedAddrBits = 1'b0;
    for (int p = 0; p < PORTS; p++) begin
      portAddr[p]    = addr_i[p*ADDR_W +: ADDR_W];
      portIdx[p]     = portAddr[p][INDEX_BITS+1:2];
      portTag[p]     = portAddr[p][ADDR_W-1:INDEX_BITS+2];
      unusedAddrBits = unusedAddrBits ^ (^portAddr[p][1:0]);
      lookupHit[p]   = lineValid_q[portIdx[p]] &&
                       (tag_q[portIdx[p]] == portTag[p]) && !flush_i;
      // A waiting port that hits this cycle needs no fetch. This prevents a
      // second fetch of a line another port has just filled.
      wantFetch[p]   = (portState_q[p] == P_WAIT) && !lookupHit[p];
    end
  end

  // Valid bits. Flush has priority over a coincident fill write, so the line
  // stays invalid.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lineValid_q <= '0;
    end else if (flush_i) begin
      lineValid_q <= '0;
    end else if (fillDone) begin
      lineValid_q[fillIdx] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (fillDone) begin
      tag_q[fillIdx]  <= fillTag;
      data_q[fillIdx] <= mem_data_i;
    end
  end

  // Port FSM: state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < PORTS; p++) portState_q[p] <= P_IDLE;
      rdata_q <= '0;
    end else begin
      for (int p = 0; p < PORTS; p++) portState_q[p] <= portState_d[p];
      rdata_q <= rdata_d;
    end
  end

  // Port FSM: next state. The granted port completes only from its own fill.
  // The fill data is forwarded directly, so the port acks even if a
  // coincident flush keeps the line invalid.
  always_comb begin
    rdata_d = rdata_q;
    for (int p = 0; p < PORTS; p++) begin
      portState_d[p] = portState_q[p];
      case (portState_q[p])
        P_IDLE: begin
          if (req_i[p]) begin
            if (lookupHit[p]) begin
              portState_d[p]       = P_DONE;
              rdata_d[p*32 +: 32] = data_q[portIdx[p]];
            end else begin
              portState_d[p] = P_WAIT;
            end
          end
        end
        P_WAIT: begin
          if (fetching && (grant_q == PTR_W'(p))) begin
            if (mem_valid_i) begin
              portState_d[p]       = P_DONE;
              rdata_d[p*32 +: 32] = mem_data_i;
            end
          end else if (lookupHit[p]) begin
            portState_d[p]       = P_DONE;
            rdata_d[p*32 +: 32] = data_q[portIdx[p]];
          end
        end
        P_DONE:  portState_d[p] = P_IDLE;
        default: portState_d[p] = P_IDLE;
      endcase
    end
  end

  // Port FSM: outputs
  always_comb begin
    for (int p = 0; p < PORTS; p++) ack_o[p] = (portState_q[p] == P_DONE);
    rdata_o = rdata_q;
  end

  // Fill FSM: state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fillState_q <= F_IDLE;
      grant_q     <= '0;
      rr_q        <= '0;
      memAddr_q   <= '0;
    end else begin
      fillState_q <= fillState_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      memAddr_q   <= memAddr_d;
    end
  end

  // Fill FSM: next state. Grant the first waiting port at or after the
  // round-robin pointer. The address is latched so it stays stable for the
  // whole fetch.
  always_comb begin
    fillState_d = fillState_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    memAddr_d   = memAddr_q;
    grantFound  = 1'b0;
    grantIdx    = '0;
    for (int k = 0; k < PORTS; k++) begin
      if (!grantFound && wantFetch[(int'(rr_q) + k) % PORTS]) begin
        grantFound = 1'b1;
        grantIdx   = PTR_W'((int'(rr_q) + k) % PORTS);
      end
    end
    case (fillState_q)
      F_IDLE: begin
        if (grantFound) begin
          fillState_d = F_FETCH;
          grant_d     = grantIdx;
          memAddr_d   = {portAddr[grantIdx][ADDR_W-1:2], 2'b00};
        end
      end
      F_FETCH: begin
        if (mem_valid_i) begin
          fillState_d = F_IDLE;
          rr_d        = (grant_q == PTR_W'(PORTS-1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: fillState_d = F_IDLE;
    endcase
  end

  // Fill FSM: outputs
  always_comb begin
    mem_req_o  = fetching;
    mem_addr_o = memAddr_q;
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hitCount_q, missCount_q;
  logic [3:0]  hitsNow, missesNow;
  logic [32:0] hitSum, missSum;

  // Count first lookups only, meaning IDLE ports presenting a request.
  // Re-lookups from WAIT are not counted.
  always_comb begin
    hitsNow   = '0;
    missesNow = '0;
    for (int p = 0; p < PORTS; p++) begin
      if ((portState_q[p] == P_IDLE) && req_i[p]) begin
        if (lookupHit[p]) hitsNow   = hitsNow + 4'd1;
        else              missesNow = missesNow + 4'd1;
      end
    end
    hitSum  = {1'b0, hitCount_q}  + {29'd0, hitsNow};
    missSum = {1'b0, missCount_q} + {29'd0, missesNow};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hitCount_q  <= '0;
      missCount_q <= '0;
    end else begin
      hitCount_q  <= hitSum[32]  ? '1 : hitSum[31:0];
      missCount_q <= missSum[32] ? '1 : missSum[31:0];
    end
  end

  assign hit_count_o  = hitCount_q;
  assign miss_count_o = missCount_q;
`endif

  // Clients must hold req while their miss is outstanding.
  for (genvar p = 0; p < PORTS; p++) begin : gReqHeld
    assert property (@(posedge clock) disable iff (!reset_n)
                     (portState_q[p] == P_WAIT) |-> req_i[p]);
  end

endmodule

// File: tb/tb_multiport_read_cache.sv
// tb_multiport_read_cache
//   Scoreboard bench for multiport_read_cache. A driver issues queued reads on
//   each port and pushes the word the memory holds at that address. A monitor
//   pops and compares on every ack. A memory responder answers fetches, logs
//   each fetched address and can pulse flush alongside the data. Directed
//   scenarios check fetch counts, fetch order and hit latency. A randomized
//   phase follows.
module tb_multiport_read_cache;
  localparam int INDEX_BITS = 6;
  localparam int PORTS      = 2;
  localparam int ADDR_W     = 32;

  logic                    clock;
  logic                    reset_n;
  logic                    flush;
  logic [PORTS-1:0]        req;
  logic [PORTS*ADDR_W-1:0] addr;
  logic [PORTS-1:0]        ack;
  logic [PORTS*32-1:0]     rdata;
  logic                    memReq;
  logic [ADDR_W-1:0]       memAddr;
  logic                    memValid;
  logic [31:0]             memData;
`ifdef CACHE_STATS_EN
  logic [31:0]             hitCount;
  logic [31:0]             missCount;
`endif

  multiport_read_cache #(
    .INDEX_BITS(INDEX_BITS), .PORTS(PORTS), .ADDR_W(ADDR_W)
  ) dut (
    .clock(clock), .reset_n(reset_n), .flush_i(flush),
    .req_i(req), .addr_i(addr), .ack_o(ack), .rdata_o(rdata),
    .mem_req_o(memReq), .mem_addr_o(memAddr),
    .mem_valid_i(memValid), .mem_data_i(memData)
`ifdef CACHE_STATS_EN
    , .hit_count_o(hitCount), .miss_count_o(missCount)
`endif
  );

  int errors = 0;
  int checks = 0;
  int cycleCnt = 0;

  logic [31:0] portQ [PORTS][$];
  logic [31:0] expQ  [PORTS][$];
  logic [31:0] fetchLog [$];
  int          issueCycle [PORTS];
  int          lastLat [PORTS];

  int fixedLat    = 1;
  bit randomLat   = 1'b0;
  bit randomFlush = 1'b0;
  bit flushOnFill = 1'b0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cycleCnt <= cycleCnt + 1;

  // Memory contents. Any word not listed is a fixed hash of its word address.
  function automatic logic [31:0] wordAt(input logic [31:0] a);
    if (a[31:2] == 30'h40) return 32'hDEADBEEF;
    return ({a[31:2], 2'b00} * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] fetchAt(input int i);
    if (fetchLog.size() > i) return fetchLog[i];
    return 32'hFFFFFFFF;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int p, input logic [31:0] a);
    portQ[p].push_back(a);
  endtask

  task automatic waitIdle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 20000 && !done; i++) begin
      @(negedge clock);
      #2;
      done = (req == '0) && !memReq;
      for (int p = 0; p < PORTS; p++)
        if (portQ[p].size() != 0 || expQ[p].size() != 0) done = 1'b0;
    end
    checkOutput({name, "_idle"}, 64'(done), 64'd1);
  endtask

  // Driver: present the next queued address on each free port, and drop req
  // on ack.
  initial begin : driver
    logic [31:0] a;
    req  = '0;
    addr = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        req = '0;
        for (int p = 0; p < PORTS; p++) portQ[p].delete();
      end else begin
        for (int p = 0; p < PORTS; p++) begin
          if (req[p]) begin
            if (ack[p]) req[p] = 1'b0;
          end else if (portQ[p].size() > 0) begin
            a = portQ[p].pop_front();
            addr[p*ADDR_W +: ADDR_W] = a;
            req[p] = 1'b1;
            expQ[p].push_back(wordAt(a));
            issueCycle[p] = cycleCnt;
          end
        end
      end
    end
  end

  // Monitor: every ack must match the oldest outstanding expectation.
  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        for (int p = 0; p < PORTS; p++) expQ[p].delete();
      end else begin
        for (int p = 0; p < PORTS; p++) begin
          if (ack[p]) begin
            lastLat[p] = cycleCnt - issueCycle[p];
            if (expQ[p].size() == 0) begin
              checkOutput($sformatf("unexpected_ack_p%0d", p), 64'd1, 64'd0);
            end else begin
              e = expQ[p].pop_front();
              checkOutput($sformatf("rdata_p%0d", p),
                          64'(rdata[p*32 +: 32]), 64'(e));
            end
          end
        end
      end
    end
  end

  // Memory responder: waits a latency, then returns one data beat.
  initial begin : memModel
    bit          busy;
    int          cnt;
    logic [31:0] seenAddr;
    busy = 1'b0; cnt = 0; seenAddr = '0;
    memValid = 1'b0; memData = '0; flush = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n || memValid) begin
        memValid = 1'b0;
        flush    = 1'b0;
        busy     = 1'b0;
      end else if (memReq) begin
        if (!busy) begin
          busy     = 1'b1;
          cnt      = randomLat ? int'($urandom_range(0, 4)) : fixedLat;
          seenAddr = memAddr;
        end
        if (cnt == 0) begin
          checkOutput("mem_addr_stable", 64'(memAddr), 64'({seenAddr[31:2], 2'b00}));
          fetchLog.push_back(memAddr);
          memData  = wordAt(memAddr);
          memValid = 1'b1;
          flush    = flushOnFill || (randomFlush && ($urandom_range(0, 7) == 0));
        end else begin
          cnt--;
        end
      end
    end
  end

  initial begin : test
    int          base;
    int          p;
    bit          found;
    logic [31:0] a;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    checkOutput("reset_ack", 64'(ack), 64'd0);
    checkOutput("reset_mem_req", 64'(memReq), 64'd0);
    checkOutput("reset_mem_addr", 64'(memAddr), 64'd0);
    checkOutput("reset_rdata", 64'(rdata), 64'd0);
    #1 reset_n = 1'b1;

    // Cold read, then a hit. Fill on port 0 moves rr to 1.
    fixedLat = 3;
    base = fetchLog.size();
    applyStimulus(0, 32'h100);
    waitIdle("cold");
    checkOutput("cold_fetch_count", 64'(fetchLog.size() - base), 64'd1);
    checkOutput("cold_fetch_addr", 64'(fetchAt(base)), 64'h100);
    base = fetchLog.size();
    applyStimulus(0, 32'h102);
    waitIdle("reread");
    checkOutput("reread_fetch_count", 64'(fetchLog.size() - base), 64'd0);
    checkOutput("reread_latency", 64'(lastLat[0]), 64'd1);

    // Both ports miss the same word. One fetch serves both. Port 1 is granted,
    // so rr returns to 0.
    fixedLat = 1;
    base = fetchLog.size();
    applyStimulus(0, 32'h40);
    applyStimulus(1, 32'h40);
    waitIdle("same_addr");
    checkOutput("same_addr_fetch_count", 64'(fetchLog.size() - base), 64'd1);

    // rr = 0: port 0 goes first.
    base = fetchLog.size();
    applyStimulus(0, 32'h200);
    applyStimulus(1, 32'h304);
    waitIdle("rr0");
    checkOutput("rr0_first", 64'(fetchAt(base)), 64'h200);
    checkOutput("rr0_second", 64'(fetchAt(base + 1)), 64'h304);

    // A solo port-0 fill sets rr to 1, so port 1 goes first next.
    applyStimulus(0, 32'h600);
    waitIdle("solo");
    base = fetchLog.size();
    applyStimulus(0, 32'h400);
    applyStimulus(1, 32'h508);
    waitIdle("rr1");
    checkOutput("rr1_first", 64'(fetchAt(base)), 64'h508);
    checkOutput("rr1_second", 64'(fetchAt(base + 1)), 64'h400);

    // Conflict on index 0: each read replaces the previous tag.
    base = fetchLog.size();
    applyStimulus(0, 32'h000);
    waitIdle("conflict_a");
    applyStimulus(0, 32'h000 + (32'd1 << (INDEX_BITS + 2)));
    waitIdle("conflict_b");
    applyStimulus(0, 32'h000);
    waitIdle("conflict_c");
    checkOutput("conflict_fetch_count", 64'(fetchLog.size() - base), 64'd3);

    // Flush coincident with the fill: data is still returned, but the line is
    // not kept.
    flushOnFill = 1'b1;
    base = fetchLog.size();
    applyStimulus(1, 32'h700);
    waitIdle("flush_fill");
    flushOnFill = 1'b0;
    applyStimulus(1, 32'h700);
    waitIdle("flush_reread");
    checkOutput("flush_fetch_count", 64'(fetchLog.size() - base), 64'd2);

    // Randomized traffic over a small address pool.
    randomLat   = 1'b1;
    randomFlush = 1'b1;
    for (int i = 0; i < 240; i++) begin
      p = int'($urandom_range(0, PORTS - 1));
      a = {22'd0, 2'($urandom_range(0, 3)), 3'd0, 3'($urandom_range(0, 7)),
           2'($urandom_range(0, 3))};
      applyStimulus(p, a);
    end
    waitIdle("random");
    randomLat   = 1'b0;
    randomFlush = 1'b0;

    // Reset in the middle of a fetch.
    fixedLat = 20;
    applyStimulus(0, 32'h800);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clock);
      #1 found = memReq;
    end
    checkOutput("fetch_started", 64'(found), 64'd1);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("midrst_mem_req", 64'(memReq), 64'd0);
    checkOutput("midrst_ack", 64'(ack), 64'd0);
`ifdef CACHE_STATS_EN
    checkOutput("midrst_hit_count", 64'(hitCount), 64'd0);
    checkOutput("midrst_miss_count", 64'(missCount), 64'd0);
`endif
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b1;
    fixedLat = 1;
    base = fetchLog.size();
    applyStimulus(0, 32'h100);
    waitIdle("post_reset_a");
    checkOutput("post_reset_miss", 64'(fetchLog.size() - base), 64'd1);
    applyStimulus(1, 32'h100);
    waitIdle("post_reset_b");
    checkOutput("post_reset_hit", 64'(fetchLog.size() - base), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
